// File: rtl/data_mem_port_if.sv
// Processor-side bundle for data_mem_port: request/address/data in, status/read data back.
interface data_mem_port_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd_req;
    logic              wr_req;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [15:0]       acc_cnt;

    modport master (
        output addr, wdata, rd_req, wr_req,
        input  busy, done, err, rdata, acc_cnt
    );

    modport slave (
        input  addr, wdata, rd_req, wr_req,
        output busy, done, err, rdata, acc_cnt
    );
endinterface

// File: rtl/data_mem_port.sv
// Single-access memory port: turns processor read/write requests into RAM cycles,
// waits out the RAM read latency, and reports done/err pulses plus an access count.
module data_mem_port #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 262144,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_port_if.slave    bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR} state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable and every address passes.
    localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [2:0]      RD_LAT_L = RD_LAT[2:0];

    state_t            state_reg;
    logic [2:0]        wait_cnt_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [15:0]       acc_cnt_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_we_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic        one_req;
    logic        both_req;
    logic        addr_ok;
    logic [15:0] acc_cnt_next;

    assign one_req      = bus.rd_req ^ bus.wr_req;
    assign both_req     = bus.rd_req & bus.wr_req;
    assign addr_ok      = ({1'b0, bus.addr} < DEPTH_L);
    assign acc_cnt_next = (acc_cnt_reg == 16'hFFFF) ? acc_cnt_reg : acc_cnt_reg + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            acc_cnt_reg   <= '0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
        end else begin
            // Pulses and the write strobe default low so each lasts exactly one cycle.
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            mem_we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (both_req) begin
                        err_reg <= 1'b1;
                    end else if (one_req) begin
                        if (!addr_ok) begin
                            err_reg <= 1'b1;
                        end else begin
                            mem_addr_reg <= bus.addr;
                            busy_reg     <= 1'b1;
                            if (bus.rd_req) begin
                                state_reg    <= RD_WAIT;
                                wait_cnt_reg <= RD_LAT_L;
                            end else begin
                                state_reg     <= WR;
                                mem_we_reg    <= 1'b1;
                                mem_wdata_reg <= bus.wdata;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    // Counter reads 1 on the RD_LAT-th edge after acceptance.
                    if (wait_cnt_reg == 3'd1) begin
                        rdata_reg   <= mem_rdata;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        acc_cnt_reg <= acc_cnt_next;
                        state_reg   <= IDLE;
                    end
                end
                WR: begin
                    done_reg    <= 1'b1;
                    busy_reg    <= 1'b0;
                    acc_cnt_reg <= acc_cnt_next;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.err     = err_reg;
    assign bus.rdata   = rdata_reg;
    assign bus.acc_cnt = acc_cnt_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_we      = mem_we_reg;
    assign mem_wdata   = mem_wdata_reg;
endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: reads, writes, rejects, busy requests, reset abort, saturation.
module tb_data_mem_port;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    data_mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

    logic [ADDR_W-1:0] mem_addr, mem_addr2;
    logic              mem_we, mem_we2;
    logic [DATA_W-1:0] mem_wdata, mem_wdata2, mem_rdata;

    data_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(262144), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    data_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(1024), .RD_LAT(2)) dut_small (
        .clk(clk), .rst(rst), .bus(bus2),
        .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .mem_rdata(8'h00)
    );

    // RAM model: data for an address is visible RD_LAT=2 edges after the address register loads.
    logic [DATA_W-1:0] ram [0:262143];
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (load_en) ram[load_addr] <= load_data;
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        bus.addr = '0; bus.wdata = '0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        bus2.addr = '0; bus2.wdata = '0; bus2.rd_req = 1'b0; bus2.wr_req = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;

        // Requests present during reset must be ignored.
        bus.wr_req = 1'b1; bus.addr = 18'h00005; bus.wdata = 8'h11;
        step(); step();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_acc", bus.acc_cnt, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_we", mem_we, 0);
        check("rst_wdata", mem_wdata, 0);
        bus.wr_req = 1'b0;
        rst = 1'b0;
        $display("reset checked");

        load_en = 1'b1; load_addr = 18'h00010; load_data = 8'hA5;
        step();
        load_en = 1'b0;

        // Read of 0x00010, RD_LAT=2
        bus.rd_req = 1'b1; bus.addr = 18'h00010;
        step();
        bus.rd_req = 1'b0;
        check("rd_e0_maddr", mem_addr, 18'h00010);
        check("rd_e0_busy", bus.busy, 1);
        check("rd_e0_done", bus.done, 0);
        step();
        check("rd_e1_busy", bus.busy, 1);
        check("rd_e1_done", bus.done, 0);
        step();
        check("rd_e2_done", bus.done, 1);
        check("rd_e2_rdata", bus.rdata, 8'hA5);
        check("rd_e2_busy", bus.busy, 0);
        check("rd_e2_acc", bus.acc_cnt, 1);
        step();
        check("rd_e3_done", bus.done, 0);
        $display("read 0x00010 -> %0h", bus.rdata);

        // Write 0x5C to top address
        bus.wr_req = 1'b1; bus.addr = 18'h3FFFF; bus.wdata = 8'h5C;
        step();
        bus.wr_req = 1'b0;
        check("wr_e0_we", mem_we, 1);
        check("wr_e0_maddr", mem_addr, 18'h3FFFF);
        check("wr_e0_wdata", mem_wdata, 8'h5C);
        check("wr_e0_busy", bus.busy, 1);
        check("wr_e0_done", bus.done, 0);
        step();
        check("wr_e1_we", mem_we, 0);
        check("wr_e1_done", bus.done, 1);
        check("wr_e1_busy", bus.busy, 0);
        check("wr_e1_acc", bus.acc_cnt, 2);
        check("wr_keeps_rdata", bus.rdata, 8'hA5);
        step();
        check("wr_idle_maddr", mem_addr, 18'h3FFFF);
        check("wr_idle_wdata", mem_wdata, 8'h5C);
        $display("write 0x3FFFF <- 5c");

        bus.rd_req = 1'b1; bus.addr = 18'h3FFFF;
        step();
        bus.rd_req = 1'b0;
        step(); step();
        check("rb_done", bus.done, 1);
        check("rb_rdata", bus.rdata, 8'h5C);
        check("rb_acc", bus.acc_cnt, 3);
        $display("read 0x3FFFF -> %0h", bus.rdata);

        // Both requests high: reject
        bus.rd_req = 1'b1; bus.wr_req = 1'b1; bus.addr = 18'h00020; bus.wdata = 8'h99;
        step();
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        check("both_err", bus.err, 1);
        check("both_done", bus.done, 0);
        check("both_we", mem_we, 0);
        check("both_busy", bus.busy, 0);
        check("both_maddr", mem_addr, 18'h3FFFF);
        check("both_rdata", bus.rdata, 8'h5C);
        step();
        check("both_err_pulse", bus.err, 0);
        check("both_acc", bus.acc_cnt, 3);
        $display("dual request rejected");

        // Out-of-range on DEPTH=1024 instance, then the last legal address
        bus2.rd_req = 1'b1; bus2.addr = 18'd1024;
        step();
        check("oor_err", bus2.err, 1);
        check("oor_maddr", mem_addr2, 0);
        check("oor_busy", bus2.busy, 0);
        bus2.addr = 18'd1023;
        step();
        bus2.rd_req = 1'b0;
        check("edge_err", bus2.err, 0);
        check("edge_busy", bus2.busy, 1);
        check("edge_maddr", mem_addr2, 18'd1023);
        step(); step();
        check("edge_done", bus2.done, 1);
        bus2.wr_req = 1'b1; bus2.addr = 18'h3FFFF; bus2.wdata = 8'h33;
        step();
        bus2.wr_req = 1'b0;
        check("oor_wr_err", bus2.err, 1);
        check("oor_wr_we", mem_we2, 0);
        $display("out-of-range requests rejected");

        // Write request while a read is in flight
        bus.rd_req = 1'b1; bus.addr = 18'h00010;
        step();
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b1; bus.wdata = 8'hFF;
        step();
        check("bz_e1_we", mem_we, 0);
        check("bz_e1_err", bus.err, 0);
        check("bz_e1_busy", bus.busy, 1);
        step();
        bus.wr_req = 1'b0;
        check("bz_e2_we", mem_we, 0);
        check("bz_e2_err", bus.err, 0);
        check("bz_e2_done", bus.done, 1);
        check("bz_e2_rdata", bus.rdata, 8'hA5);
        check("bz_e2_acc", bus.acc_cnt, 4);
        step();
        check("bz_e3_we", mem_we, 0);
        check("bz_e3_busy", bus.busy, 0);
        $display("request during read ignored");

        // Reset during a write
        bus.wr_req = 1'b1; bus.addr = 18'h00030; bus.wdata = 8'h77;
        step();
        bus.wr_req = 1'b0;
        check("ra_e0_we", mem_we, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ra_we", mem_we, 0);
        check("ra_done", bus.done, 0);
        check("ra_busy", bus.busy, 0);
        check("ra_acc", bus.acc_cnt, 0);
        check("ra_rdata", bus.rdata, 0);
        check("ra_maddr", mem_addr, 0);
        check("ra_wdata", mem_wdata, 0);
        step();
        check("ra_no_late_done", bus.done, 0);
        bus.rd_req = 1'b1; bus.addr = 18'h00010;
        step();
        bus.rd_req = 1'b0;
        check("ra_next_busy", bus.busy, 1);
        step(); step();
        check("ra_next_done", bus.done, 1);
        check("ra_next_rdata", bus.rdata, 8'hA5);
        check("ra_next_acc", bus.acc_cnt, 1);
        $display("reset abort, next read -> %0h", bus.rdata);

        // Counter preload near the top, then back-to-back writes through saturation
        step();
        force dut.acc_cnt_reg = 16'hFFFD;
        step();
        release dut.acc_cnt_reg;
        bus.wr_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.addr = 18'h00100 + 18'(k); bus.wdata = 8'(k);
            step();
            check("b2b_we", mem_we, 1);
            check("b2b_busy", bus.busy, 1);
            check("b2b_maddr", mem_addr, 18'h00100 + 18'(k));
            step();
            check("b2b_done", bus.done, 1);
            check("b2b_acc", bus.acc_cnt, (k >= 2) ? 16'hFFFF : 16'hFFFE);
            $display("b2b write %0d acc_cnt=%0h", k, bus.acc_cnt);
        end
        bus.wr_req = 1'b0;
        step();
        check("sat_idle_busy", bus.busy, 0);
        check("sat_hold", bus.acc_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
